// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if: fetch/data request ports and memory bus of mem_arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_done;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_we;
  logic [2:0]  d_funct3;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_done;
  logic [31:0] d_rdata;

  logic        write_mem;
  logic [2:0]  funct3;
  logic [31:0] write_address;
  logic [31:0] write_data;
  logic [31:0] read_address;
  logic [31:0] read_data;
  logic        busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_funct3, d_addr, d_wdata, read_data,
    output if_gnt, if_done, if_rdata, d_gnt, d_done, d_rdata,
           write_mem, funct3, write_address, write_data, read_address, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_funct3, d_addr, d_wdata, read_data,
    input  if_gnt, if_done, if_rdata, d_gnt, d_done, d_rdata,
           write_mem, funct3, write_address, write_data, read_address, busy
  );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter: round-robin sharing of single-port memory by fetch and load/store
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module mem_arbiter #(
  parameter int READ_LATENCY = 1
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } state_t;

  localparam logic [2:0] c_fetch_funct3 = 3'b010;
  localparam logic [2:0] c_wait_load    = (READ_LATENCY > 0) ? 3'(READ_LATENCY - 1) : 3'd0;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_last_d;
  logic        r_we;
  logic [2:0]  r_cnt;
  logic [2:0]  r_funct3;
  logic [31:0] r_write_address;
  logic [31:0] r_write_data;
  logic [31:0] r_read_address;
  logic [31:0] r_if_rdata;
  logic [31:0] r_d_rdata;
  logic        r_if_done;
  logic        r_d_done;

  logic        w_gnt_if;
  logic        w_gnt_d;
  logic        w_capture;
  logic        w_store_done;

  // r_last_d doubles as the owner of the transaction in flight.
  always_comb begin
    w_state_next = r_state;
    w_gnt_if     = 1'b0;
    w_gnt_d      = 1'b0;
    w_capture    = 1'b0;
    w_store_done = 1'b0;
    case (r_state)
      IDLE: begin
        w_gnt_d  = rst_n && bus.d_req && (!bus.if_req || !r_last_d);
        w_gnt_if = rst_n && bus.if_req && !w_gnt_d;
        if (w_gnt_d || w_gnt_if) begin
          w_state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (r_we) begin
          w_store_done = 1'b1;
          w_state_next = IDLE;
        end else if (READ_LATENCY == 0) begin
          w_capture    = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == 3'd0) begin
          w_capture    = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_last_d        <= 1'b0;
      r_we            <= 1'b0;
      r_cnt           <= 3'd0;
      r_funct3        <= c_fetch_funct3;
      r_write_address <= 32'd0;
      r_write_data    <= 32'd0;
      r_read_address  <= 32'd0;
      r_if_rdata      <= 32'd0;
      r_d_rdata       <= 32'd0;
      r_if_done       <= 1'b0;
      r_d_done        <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_if_done <= w_capture && !r_last_d;
      r_d_done  <= (w_capture && r_last_d) || w_store_done;

      if (w_gnt_d) begin
        r_last_d <= 1'b1;
        r_we     <= bus.d_we;
        r_funct3 <= bus.d_funct3;
        if (bus.d_we) begin
          r_write_address <= bus.d_addr;
          r_write_data    <= bus.d_wdata;
        end else begin
          r_read_address  <= bus.d_addr;
        end
      end else if (w_gnt_if) begin
        r_last_d       <= 1'b0;
        r_we           <= 1'b0;
        r_funct3       <= c_fetch_funct3;
        r_read_address <= bus.if_addr;
      end

      if (r_state == ACCESS && !r_we) begin
        r_cnt <= c_wait_load;
      end else if (r_state == WAIT && r_cnt != 3'd0) begin
        r_cnt <= r_cnt - 3'd1;
      end

      if (w_capture) begin
        if (r_last_d) begin
          r_d_rdata  <= bus.read_data;
        end else begin
          r_if_rdata <= bus.read_data;
        end
      end
    end
  end

  assign bus.if_gnt        = w_gnt_if;
  assign bus.d_gnt         = w_gnt_d;
  assign bus.if_done       = r_if_done;
  assign bus.d_done        = r_d_done;
  assign bus.if_rdata      = r_if_rdata;
  assign bus.d_rdata       = r_d_rdata;
  assign bus.write_mem     = (r_state == ACCESS) && r_we;
  assign bus.funct3        = r_funct3;
  assign bus.write_address = r_write_address;
  assign bus.write_data    = r_write_data;
  assign bus.read_address  = r_read_address;
  assign bus.busy          = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter: three arbiters (read latency 0, 1, 3) against a cycle-level model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_mem_arbiter;

  localparam int PH_CONT  = 0;
  localparam int PH_FETCH = 1;
  localparam int PH_RAND  = 2;
  localparam int PH_QUIET = 3;
  localparam int PH_LOAD  = 4;
  localparam int END_CYC  = 800;

  logic clk = 1'b0;
  logic rst_n;
  int   gcyc   = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  function automatic int phase_of(input int c);
    if (c < 40)              return PH_CONT;
    if (c < 70)              return PH_FETCH;
    if (c < 400)             return PH_RAND;
    if (c == 420 || c == 427) return PH_LOAD;
    if (c < 430)             return PH_QUIET;
    if (c < 780)             return PH_RAND;
    return PH_QUIET;
  endfunction

  // Memory contents are a fixed function of the address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h0040_0093;
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input int lat, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL lat%0d %s cycle %0d: got %h expected %h", lat, nm, gcyc, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_inst
    localparam int LAT    = (gi == 0) ? 0 : (gi == 1) ? 1 : 3;
    localparam int RD_DLY = (gi == 0) ? 2 : (gi == 1) ? 3 : 5;

    mem_arbiter_if bus ();

    mem_arbiter #(.READ_LATENCY(LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );

    logic [31:0] hist [0:7];
    always @(posedge clk) begin
      hist[0] <= bus.read_address;
      for (int j = 1; j < 8; j++) hist[j] <= hist[j-1];
    end
    always_comb begin
      bus.read_data = (LAT == 0) ? memf(bus.read_address) : memf(hist[(LAT == 0) ? 0 : LAT - 1]);
    end

    int          idle_at = 0, wm_at = -1, ifd_at = -1, dd_at = -1;
    logic        last_d = 1'b0, d_is_store = 1'b0;
    logic [31:0] e_raddr = '0, e_waddr = '0, e_wdata = '0, e_ifr = '0, e_dr = '0;
    logic [31:0] pend_if = '0, pend_d = '0;
    logic [2:0]  e_f3 = 3'b010;
    logic        e_gi, e_gd;
    int          k;
    int          gnt_if_cyc = 0, gnt_d_cyc = 0, last_gnt_cyc = 0;
    logic        d_obs_store = 1'b0, last_gnt_fetch = 1'b0, first_ifd = 1'b1;
    logic        ig_seen, dg_seen, store_sent = 1'b0;
    int          order[$];
    int          fcount = 0, icount = 0, ph;

    initial begin
      bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0;
      bus.d_funct3 = '0; bus.d_addr = '0; bus.d_wdata = '0;
      forever begin
        @(negedge clk);
        k = gcyc;
        if (!rst_n) begin
          idle_at = 0; wm_at = -1; ifd_at = -1; dd_at = -1; last_d = 1'b0;
          e_raddr = '0; e_waddr = '0; e_wdata = '0; e_ifr = '0; e_dr = '0; e_f3 = 3'b010;
        end
        if (k == ifd_at) e_ifr = pend_if;
        if (k == dd_at && !d_is_store) e_dr = pend_d;

        // Arbitration rule: lone requester wins; on a tie the port not granted last.
        e_gd = rst_n && (k >= idle_at) && bus.d_req && (!bus.if_req || !last_d);
        e_gi = rst_n && (k >= idle_at) && bus.if_req && !e_gd;

        chk(LAT, "if_gnt",        bus.if_gnt,        e_gi);
        chk(LAT, "d_gnt",         bus.d_gnt,         e_gd);
        chk(LAT, "busy",          bus.busy,          k < idle_at);
        chk(LAT, "write_mem",     bus.write_mem,     k == wm_at);
        chk(LAT, "if_done",       bus.if_done,       k == ifd_at);
        chk(LAT, "d_done",        bus.d_done,        k == dd_at);
        chk(LAT, "if_rdata",      bus.if_rdata,      e_ifr);
        chk(LAT, "d_rdata",       bus.d_rdata,       e_dr);
        chk(LAT, "funct3",        bus.funct3,        e_f3);
        chk(LAT, "write_address", bus.write_address, e_waddr);
        chk(LAT, "write_data",    bus.write_data,    e_wdata);
        chk(LAT, "read_address",  bus.read_address,  e_raddr);

        // Hand-computed pins on DUT observations, independent of the model.
        if (rst_n && bus.if_done) begin
          chk(LAT, "if_latency", k - gnt_if_cyc, RD_DLY);
          if (first_ifd) begin
            first_ifd = 1'b0;
            chk(LAT, "first_fetch_data", bus.if_rdata, 32'h0040_0093);
          end
        end
        if (rst_n && bus.d_done) chk(LAT, "d_latency", k - gnt_d_cyc, d_obs_store ? 2 : RD_DLY);
        if (k == 5) begin
          chk(LAT, "store_strobe", bus.write_mem,     1);
          chk(LAT, "store_addr",   bus.write_address, 32'h0000_0100);
          chk(LAT, "store_data",   bus.write_data,    32'hDEAD_BEEF);
        end
        if (k == 6) chk(LAT, "store_done", bus.d_done, 1);
        if (bus.if_gnt && phase_of(k) == PH_FETCH && last_gnt_fetch && last_gnt_cyc >= 40)
          chk(LAT, "fetch_spacing", k - last_gnt_cyc, RD_DLY);
        if (rst_n && (bus.if_gnt || bus.d_gnt) && order.size() < 4) order.push_back(int'(bus.d_gnt));
        if (k == 40) begin
          chk(LAT, "tie_count", order.size(), 4);
          for (int j = 0; j < order.size(); j++) chk(LAT, "tie_order", order[j], (j % 2 == 0) ? 1 : 0);
        end
        if (bus.d_gnt)  begin gnt_d_cyc = k;  d_obs_store = bus.d_we; end
        if (bus.if_gnt) gnt_if_cyc = k;
        if (bus.if_gnt || bus.d_gnt) begin last_gnt_cyc = k; last_gnt_fetch = bus.if_gnt; end

        if (e_gd) begin
          last_d = 1'b1; e_f3 = bus.d_funct3; d_is_store = bus.d_we;
          if (bus.d_we) begin
            e_waddr = bus.d_addr; e_wdata = bus.d_wdata;
            wm_at = k + 1; dd_at = k + 2; idle_at = k + 2;
          end else begin
            e_raddr = bus.d_addr; pend_d = memf(bus.d_addr);
            dd_at = k + 2 + LAT; idle_at = k + 2 + LAT;
          end
        end else if (e_gi) begin
          last_d = 1'b0; e_f3 = 3'b010; e_raddr = bus.if_addr; pend_if = memf(bus.if_addr);
          ifd_at = k + 2 + LAT; idle_at = k + 2 + LAT;
        end
        ig_seen = bus.if_gnt;
        dg_seen = bus.d_gnt;

        @(posedge clk);
        #1;
        ph = phase_of(gcyc);
        if (!rst_n) begin
          bus.if_req = 0;
          bus.d_req  = 0;
        end else begin
          if (!bus.if_req || ig_seen) begin
            bus.if_req = 0;
            if (ph == PH_CONT) begin
              bus.if_req = 1; bus.if_addr = 32'h10 + 32'(icount) * 4; icount++;
            end else if (ph == PH_FETCH) begin
              bus.if_req = 1; bus.if_addr = 32'(fcount) * 4; fcount++;
            end else if (ph == PH_RAND && $urandom_range(0, 2) == 0) begin
              bus.if_req = 1; bus.if_addr = $urandom() & 32'hFFFF_FFFC;
            end
          end
          if (!bus.d_req || dg_seen) begin
            bus.d_req = 0;
            if (ph == PH_LOAD) begin
              bus.d_req = 1; bus.d_we = 0; bus.d_funct3 = 3'b010; bus.d_addr = 32'h200;
            end else if (ph == PH_CONT && !store_sent) begin
              store_sent = 1'b1;
              bus.d_req = 1; bus.d_we = 1; bus.d_funct3 = 3'b010;
              bus.d_addr = 32'h100; bus.d_wdata = 32'hDEAD_BEEF;
            end else if (ph == PH_CONT || (ph == PH_RAND && $urandom_range(0, 2) == 0)) begin
              bus.d_req = 1; bus.d_we = 1'($urandom_range(0, 1));
              bus.d_funct3 = 3'($urandom_range(0, 7));
              bus.d_addr = $urandom(); bus.d_wdata = $urandom();
            end
          end
        end
      end
    end
  end

  // Reset held for two cycles, and again mid-load (WAIT of the latency-3 unit).
  initial begin
    rst_n = 1'b0;
    for (int c = 1; c <= END_CYC; c++) begin
      @(posedge clk);
      gcyc = c;
      if (c == 3 || c == 425) begin
        #3 rst_n = 1'b1;
      end else if (c == 423) begin
        #3 rst_n = 1'b0;
      end
    end
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
